// File: rtl/fetch_pc_predictor.sv
// fetch_pc_predictor: fetch-stage PC register with a direct-mapped BTB and
// 2-bit saturating direction counters.
// Build option: define FETCH_PREDICTOR_EN to build the BTB. Without it, no
// predictor storage exists and fetch always falls through to PC+1.
// Next-PC priority: mispredict redirect, then stall (hold), then prediction.
module fetch_pc_predictor #(
   parameter int              PC_W     = 6,
   parameter int              IDX_W    = 3,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall,
   input  logic            mispredict,
   input  logic [PC_W-1:0] redirectPc,
   input  logic            resolveValid,
   input  logic [PC_W-1:0] resolvePc,
   input  logic            resolveTaken,
   input  logic [PC_W-1:0] resolveTarget,
   output logic [PC_W-1:0] pcF,
   output logic [PC_W-1:0] pcPlus1F,
   output logic            predTakenF,
   output logic [PC_W-1:0] predTargetF
);

   localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

   logic [PC_W-1:0] pc;

   assign pcF      = pc;
   assign pcPlus1F = pc + PC_ONE;

`ifdef FETCH_PREDICTOR_EN
   localparam int TAG_W   = PC_W - IDX_W;
   localparam int ENTRIES = 1 << IDX_W;

   // Tag and target need no reset: they are only used when valid is set.
   logic             btb_valid  [ENTRIES];
   logic [TAG_W-1:0] btb_tag    [ENTRIES];
   logic [PC_W-1:0]  btb_target [ENTRIES];
   logic [1:0]       btb_ctr    [ENTRIES];

   logic [IDX_W-1:0] look_idx;
   logic [TAG_W-1:0] look_tag;
   logic             look_hit;
   logic             pred_taken;

   logic [IDX_W-1:0] upd_idx;
   logic [TAG_W-1:0] upd_tag;
   logic             upd_hit;

   assign look_idx = pc[IDX_W-1:0];
   assign look_tag = pc[PC_W-1:IDX_W];
   assign upd_idx  = resolvePc[IDX_W-1:0];
   assign upd_tag  = resolvePc[PC_W-1:IDX_W];

   // Lookup for the instruction at pcF; reads the pre-update BTB contents.
   always_comb begin
      look_hit    = btb_valid[look_idx] && (btb_tag[look_idx] == look_tag);
      pred_taken  = look_hit && btb_ctr[look_idx][1];
      predTakenF  = pred_taken;
      predTargetF = pred_taken ? btb_target[look_idx] : pcPlus1F;
   end

   // Hit detection for the branch being resolved in execute.
   always_comb begin
      upd_hit = btb_valid[upd_idx] && (btb_tag[upd_idx] == upd_tag);
   end

   // Training: counter update on hit, allocate on taken miss; stall does not block it.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++) begin
            btb_valid[i] <= 1'b0;
            btb_ctr[i]   <= 2'b01;
         end
      end else if (resolveValid) begin
         if (upd_hit) begin
            if (resolveTaken) begin
               if (btb_ctr[upd_idx] != 2'b11) begin
                  btb_ctr[upd_idx] <= btb_ctr[upd_idx] + 2'b01;
               end
               btb_target[upd_idx] <= resolveTarget;
            end else if (btb_ctr[upd_idx] != 2'b00) begin
               btb_ctr[upd_idx] <= btb_ctr[upd_idx] - 2'b01;
            end
         end else if (resolveTaken) begin
            btb_valid[upd_idx]  <= 1'b1;
            btb_tag[upd_idx]    <= upd_tag;
            btb_target[upd_idx] <= resolveTarget;
            btb_ctr[upd_idx]    <= 2'b10;
         end
      end
   end
`else
   // Resolve inputs are deliberately ignored in this build.
   logic unused_resolve;
   assign unused_resolve = ^{resolveValid, resolvePc, resolveTaken, resolveTarget};

   assign predTakenF  = 1'b0;
   assign predTargetF = pcPlus1F;
`endif

   // PC register: redirect beats stall, stall holds, otherwise follow the prediction.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc <= RESET_PC;
      end else if (mispredict) begin
         pc <= redirectPc;
      end else if (!stall) begin
         pc <= predTargetF;
      end
   end

endmodule

// File: tb/tb_fetch_pc_predictor.sv
// tb_fetch_pc_predictor: randomized and directed stimulus for fetch_pc_predictor,
// checked against a behavioural model that keeps, per BTB slot, the full PC of
// the occupant, its target and an integer confidence 0..3.
module tb_fetch_pc_predictor;

   localparam int PW = 6;
   localparam int N  = 8;
   localparam int PC_MOD = 64;
`ifdef FETCH_PREDICTOR_EN
   localparam bit PRED_EN = 1'b1;
`else
   localparam bit PRED_EN = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic          clk = 1'b0;
   logic          reset;
   logic          stall;
   logic          mispredict;
   logic [PW-1:0] redirectPc;
   logic          resolveValid;
   logic [PW-1:0] resolvePc;
   logic          resolveTaken;
   logic [PW-1:0] resolveTarget;
   logic [PW-1:0] pcF;
   logic [PW-1:0] pcPlus1F;
   logic          predTakenF;
   logic [PW-1:0] predTargetF;

   always #5 clk = ~clk;

   fetch_pc_predictor #(.PC_W(6), .IDX_W(3), .RESET_PC(6'd0)) dut (
      .clk(clk), .reset(reset), .stall(stall), .mispredict(mispredict),
      .redirectPc(redirectPc), .resolveValid(resolveValid), .resolvePc(resolvePc),
      .resolveTaken(resolveTaken), .resolveTarget(resolveTarget),
      .pcF(pcF), .pcPlus1F(pcPlus1F), .predTakenF(predTakenF), .predTargetF(predTargetF)
   );

   // ---------------- scoreboard counters ----------------
   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int m_pc;
   bit m_has   [N];
   int m_owner [N];
   int m_tgt   [N];
   int m_conf  [N];

   task automatic model_reset();
      m_pc = 0;
      for (int i = 0; i < N; i++) begin
         m_has[i]  = 1'b0;
         m_conf[i] = 1;
      end
   endtask

   task automatic model_predict(input int pc, output bit taken, output int target);
      int slot;
      slot   = pc % N;
      taken  = PRED_EN && m_has[slot] && (m_owner[slot] == pc) && (m_conf[slot] >= 2);
      target = taken ? m_tgt[slot] : (pc + 1) % PC_MOD;
   endtask

   task automatic model_clock(input bit r, input bit s, input bit m, input int rp,
                              input bit v, input int vp, input bit vt, input int vtg);
      bit pt;
      int ptg;
      int slot;
      if (r) begin
         model_reset();
         return;
      end
      model_predict(m_pc, pt, ptg);
      if (m)       m_pc = rp;
      else if (!s) m_pc = ptg;
      if (PRED_EN && v) begin
         slot = vp % N;
         if (m_has[slot] && m_owner[slot] == vp) begin
            if (vt) begin
               m_conf[slot] = (m_conf[slot] < 3) ? m_conf[slot] + 1 : 3;
               m_tgt[slot]  = vtg;
            end else begin
               m_conf[slot] = (m_conf[slot] > 0) ? m_conf[slot] - 1 : 0;
            end
         end else if (vt) begin
            m_has[slot]   = 1'b1;
            m_owner[slot] = vp;
            m_tgt[slot]   = vtg;
            m_conf[slot]  = 2;
         end
      end
   endtask

   task automatic compare_outputs();
      bit pt;
      int ptg;
      model_predict(m_pc, pt, ptg);
      check("pcF", pcF, m_pc);
      check("pcPlus1F", pcPlus1F, (m_pc + 1) % PC_MOD);
      check("predTakenF", predTakenF, pt);
      check("predTargetF", predTargetF, ptg);
   endtask

   // ---------------- driver ----------------
   // One clock: drive inputs, let the edge happen, advance the model, check at negedge.
   task automatic step(input bit r, input bit s, input bit m, input int rp,
                       input bit v, input int vp, input bit vt, input int vtg);
      reset         = r;
      stall         = s;
      mispredict    = m;
      redirectPc    = PW'(rp);
      resolveValid  = v;
      resolvePc     = PW'(vp);
      resolveTaken  = vt;
      resolveTarget = PW'(vtg);
      @(posedge clk);
      model_clock(r, s, m, rp, v, vp, vt, vtg);
      @(negedge clk);
      compare_outputs();
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic redirect(input int target);
      step(0, 0, 1, target, 0, 0, 0, 0);
   endtask

   task automatic resolve(input int pc, input bit taken, input int target);
      step(0, 0, 0, 0, 1, pc, taken, target);
   endtask

   // ---------------- stimulus ----------------
   int pool [6];

   function automatic int pick_pc();
      if ($urandom_range(0, 1) == 1) return pool[$urandom_range(0, 5)];
      return int'($urandom_range(0, PC_MOD - 1));
   endfunction

   initial begin
      pool = '{10, 18, 26, 2, 63, 5};
      model_reset();

      // reset and sequential fetch
      step(1, 0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0);
      check("reset_pc", pcF, 0);
      check("reset_pred", predTakenF, 0);
      check("reset_target", predTargetF, 1);
      for (int i = 1; i <= 3; i++) begin
         idle();
         check("seq_pc", pcF, i);
      end
      idle();
      idle();
      check("pc_at_5", pcF, 5);

      // stall versus redirect
      step(0, 1, 0, 0, 0, 0, 0, 0);
      check("stall_hold1", pcF, 5);
      step(0, 1, 0, 0, 0, 0, 0, 0);
      check("stall_hold2", pcF, 5);
      step(0, 1, 1, 20, 0, 0, 0, 0);
      check("redirect_in_stall", pcF, 20);

      // allocate and predict
      resolve(10, 1, 40);
      redirect(10);
      idle();

      // counter hysteresis
      resolve(10, 0, 0);
      resolve(10, 0, 0);
      redirect(10);
      idle();
      resolve(10, 1, 40);
      resolve(10, 1, 40);
      resolve(10, 1, 40);
      resolve(10, 1, 40);
      resolve(10, 0, 0);
      redirect(10);
      idle();

      // tag conflict on slot 2
      resolve(10, 1, 40);
      resolve(18, 1, 50);
      redirect(10);
      redirect(18);
      idle();

      // wrap-around and same-cycle update with no bypass
      redirect(63);
      check("wrap_at_63", pcF, 63);
      idle();
      check("wrap_to_0", pcF, 0);
      redirect(63);
      step(0, 0, 0, 0, 1, 63, 1, 7);
      check("no_bypass", pcF, 0);
      redirect(63);
      idle();

      // update under stall, then reset discarding a concurrent update
      step(0, 1, 0, 0, 1, 26, 1, 33);
      redirect(26);
      idle();
      step(1, 0, 0, 0, 1, 26, 1, 44);
      check("reset_mid_pc", pcF, 0);
      redirect(26);
      check("reset_mid_pred", predTakenF, 0);

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         step($urandom_range(0, 59) == 0,
              $urandom_range(0, 3) == 0,
              $urandom_range(0, 6) == 0,
              pick_pc(),
              $urandom_range(0, 2) != 0,
              pick_pc(),
              $urandom_range(0, 2) != 0,
              int'($urandom_range(0, PC_MOD - 1)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // ---------------- watchdog ----------------
   initial begin
      #1000000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/fetch_pc_predictor.md
# fetch_pc_predictor

Fetch-stage PC generator with a direct-mapped branch target buffer (BTB) and 2-bit saturating predictors. It sits directly upstream of the IF/ID pipeline register and drives the instruction-memory address (`pcF`), `pcPlus1F` and the prediction bits that travel with the fetched instruction. Branch outcomes resolved in execute train the predictor. A mispredict redirect from execute overrides all other next-PC sources.

## Interface
Parameters:
- `PC_W`, default 6: PC / instruction-address width (word-addressed).
- `IDX_W`, default 3: BTB index width; the BTB has 2^IDX_W entries.
- `RESET_PC`, default 0: PC value loaded on reset.

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `stall`  in  1  hazard-unit stall; holds the PC.
- `mispredict`  in  1  execute-stage redirect request.
- `redirectPc`  in  PC_W  correct next PC when `mispredict`=1.
- `resolveValid`  in  1  a branch resolved in execute this cycle.
- `resolvePc`  in  PC_W  PC of the resolved branch.
- `resolveTaken`  in  1  actual direction of the resolved branch.
- `resolveTarget`  in  PC_W  actual taken target.
- `pcF`  out  PC_W  current fetch PC (registered).
- `pcPlus1F`  out  PC_W  `pcF`+1, wrapping modulo 2^PC_W.
- `predTakenF`  out  1  prediction for the instruction at `pcF`.
- `predTargetF`  out  PC_W  predicted next PC for the instruction at `pcF`.

## Operation
- **BTB entry fields:** `valid`, `tag` (PC_W−IDX_W bits), `target` (PC_W bits), `ctr` (2 bits).
- **Addressing:** index = `pc[IDX_W-1:0]`; tag = `pc[PC_W-1:IDX_W]`.
- **Lookup (combinational on `pcF`):**
  - hit = `valid` && tag match.
  - `predTakenF` = hit && `ctr[1]`.
  - `predTargetF` = `target` when `predTakenF`=1, otherwise `pcPlus1F`.
- **Next-PC priority:**
  1. `mispredict` → `redirectPc`. Wins even while `stall`=1.
  2. `stall` → hold `pcF`.
  3. Otherwise → `predTargetF`.
- **Update (when `resolveValid`=1):**
  - Hit at `resolvePc`: `ctr` saturating-increments if taken, saturating-decrements if not taken (range 00..11). If taken, `target` ← `resolveTarget`.
  - Miss and taken: allocate the entry, overwriting any occupant. Set `valid`=1, `tag`, `target` ← `resolveTarget`, `ctr`=10 (weakly taken).
  - Miss and not taken: no change.
- **Independence:** `stall` does not block updates. `mispredict` and `resolveValid` are independent inputs and may be asserted in the same cycle.
- **Reset:**
  - `pcF`=`RESET_PC`, so `pcPlus1F`=`RESET_PC`+1.
  - All `valid`=0 and all `ctr`=01, so `predTakenF`=0 and `predTargetF`=`pcPlus1F`.
  - Reset asserted mid-operation discards any update presented in the same cycle.

## Timing
- **PC latency:** one cycle. `pcF` changes on the edge after the next-PC source is presented; a redirect is visible on `pcF` one cycle after `mispredict`.
- **Prediction outputs:** combinational from `pcF` and BTB state, with no added latency.
- **Read-during-update:** an update written at edge N is visible to lookups from cycle N+1 onward. A lookup in the same cycle as an update to the same index sees the pre-update contents; there is no bypass.
- **Wrap-around:** PC `2^PC_W−1` + 1 = 0. Targets and redirects are taken verbatim, with no range check.
- **Flushing:** this block does not flush IF/ID; the hazard unit owns that.

## Configuration
- **Macro `FETCH_PREDICTOR_EN` defined:** BTB and counters are built, and behaviour is as specified above.
- **Macro `FETCH_PREDICTOR_EN` undefined:**
  - No BTB storage is built, and the `resolve*` inputs are ignored.
  - `predTakenF`=0 and `predTargetF`=`pcPlus1F` at all times.
  - Next-PC priority is unchanged: redirect, then stall, then PC+1.

## Test plan
- **Reset and sequential fetch:** assert `reset` for 2 cycles, then release with no other inputs → `pcF` = 0, 1, 2, 3 on successive cycles; `predTakenF`=0 throughout.
- **Stall versus redirect:** with `pcF`=5, hold `stall`=1 for 3 cycles → `pcF` stays 5. In the 3rd stall cycle also assert `mispredict` with `redirectPc`=20 → `pcF`=20 on the next cycle.
- **Allocate and predict:**
  - Resolve `resolvePc`=10, taken, target 40 → entry 2 allocated with `ctr`=10.
  - When `pcF` later reaches 10 → `predTakenF`=1, `predTargetF`=40, next `pcF`=40.
- **Counter hysteresis on entry 2:**
  - Two not-taken resolves at PC 10 take `ctr` 10→01→00; the next fetch at PC 10 predicts not taken (`predTargetF`=11).
  - Three taken resolves take `ctr` 00→01→10→11, and it saturates at 11.
- **Tag conflict:** PC 10 allocated with target 40, then PC 18 (same index 2) resolves taken with target 50 → entry replaced. Fetch at PC 10 predicts not taken (tag miss); fetch at PC 18 predicts 50.
- **Wrap and same-cycle update:**
  - `pcF`=63 with no prediction → next `pcF`=0.
  - Resolve PC 63 taken to 7 while `pcF`=63 → that cycle still predicts not taken; the next fetch of 63 predicts 7.
